// File: rtl/id_ex_stage_pkg.sv
// Shared widths, constants and state encodings for the decode->execute pipeline register.
package id_ex_stage_pkg;

   localparam int unsigned DATA_WIDTH  = 32;
   localparam int unsigned RDATA_WIDTH = 32;
   localparam int unsigned RADDR_WIDTH = 5;

   localparam logic [31:0] INST_NOP = 32'h0000_0013;  // addi x0, x0, 0
   localparam logic [31:0] ZERO     = 32'h0000_0000;

   typedef logic [1:0] state_t;

   // Occupancy states: nothing held, main entry only, main + skid entry
   localparam state_t ST_EMPTY = 2'd0;
   localparam state_t ST_ONE   = 2'd1;
   localparam state_t ST_TWO   = 2'd2;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode/execute/write-back bus of the ID/EX stage. The stage uses the slave modport;
// whatever drives decode and consumes execute uses the master modport.
interface id_ex_stage_if #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned INST_W  = 32,
   parameter int unsigned RADDR_W = 5
);

   logic               flush_i;
   logic               in_valid_i;
   logic               in_ready_o;
   logic [DATA_W-1:0]  pc_i;
   logic [INST_W-1:0]  inst_i;
   logic [DATA_W-1:0]  op1_i;
   logic [DATA_W-1:0]  op2_i;
   logic [RADDR_W-1:0] rs1_i;
   logic [RADDR_W-1:0] rs2_i;
   logic               op2_is_reg_i;
   logic               wb_we_i;
   logic [RADDR_W-1:0] wb_waddr_i;
   logic [DATA_W-1:0]  wb_wdata_i;
   logic               out_valid_o;
   logic               out_ready_i;
   logic [DATA_W-1:0]  pc_o;
   logic [INST_W-1:0]  inst_o;
   logic [DATA_W-1:0]  op1_o;
   logic [DATA_W-1:0]  op2_o;

   modport slave (
      input  flush_i, in_valid_i, pc_i, inst_i, op1_i, op2_i, rs1_i, rs2_i, op2_is_reg_i,
      input  wb_we_i, wb_waddr_i, wb_wdata_i, out_ready_i,
      output in_ready_o, out_valid_o, pc_o, inst_o, op1_o, op2_o
   );

   modport master (
      output flush_i, in_valid_i, pc_i, inst_i, op1_i, op2_i, rs1_i, rs2_i, op2_is_reg_i,
      output wb_we_i, wb_waddr_i, wb_wdata_i, out_ready_i,
      input  in_ready_o, out_valid_o, pc_o, inst_o, op1_o, op2_o
   );

endinterface

// File: rtl/id_ex_entry.sv
// One payload slot of the ID/EX stage. Loads on load_i. With ID_EX_BYPASS_EN defined it
// also keeps rs1/rs2/op2_is_reg and patches its operands from the write-back port every
// cycle, including on the cycle it captures new data.
module id_ex_entry
   import id_ex_stage_pkg::*;
#(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned INST_W  = 32,
   parameter int unsigned RADDR_W = 5
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               load_i,
   input  logic [DATA_W-1:0]  pc_i,
   input  logic [INST_W-1:0]  inst_i,
   input  logic [DATA_W-1:0]  op1_i,
   input  logic [DATA_W-1:0]  op2_i,
`ifdef ID_EX_BYPASS_EN
   input  logic [RADDR_W-1:0] rs1_i,
   input  logic [RADDR_W-1:0] rs2_i,
   input  logic               op2_is_reg_i,
   input  logic               wb_we_i,
   input  logic [RADDR_W-1:0] wb_waddr_i,
   input  logic [DATA_W-1:0]  wb_wdata_i,
   output logic [RADDR_W-1:0] rs1_o,
   output logic [RADDR_W-1:0] rs2_o,
   output logic               op2_is_reg_o,
`endif
   output logic [DATA_W-1:0]  pc_o,
   output logic [INST_W-1:0]  inst_o,
   output logic [DATA_W-1:0]  op1_o,
   output logic [DATA_W-1:0]  op2_o
);

   logic [DATA_W-1:0] r_pc;
   logic [INST_W-1:0] r_inst;
   logic [DATA_W-1:0] r_op1;
   logic [DATA_W-1:0] r_op2;

`ifdef ID_EX_BYPASS_EN
   logic [RADDR_W-1:0] r_rs1;
   logic [RADDR_W-1:0] r_rs2;
   logic               r_op2_is_reg;
   logic [RADDR_W-1:0] w_rs1_src;
   logic [RADDR_W-1:0] w_rs2_src;
   logic               w_is_reg_src;
   logic [DATA_W-1:0]  w_op1_src;
   logic [DATA_W-1:0]  w_op2_src;
   logic [DATA_W-1:0]  w_op1_d;
   logic [DATA_W-1:0]  w_op2_d;

   // Select the operand source (new data or held data), then patch it from write-back
   always_comb begin
      w_rs1_src    = load_i ? rs1_i        : r_rs1;
      w_rs2_src    = load_i ? rs2_i        : r_rs2;
      w_is_reg_src = load_i ? op2_is_reg_i : r_op2_is_reg;
      w_op1_src    = load_i ? op1_i        : r_op1;
      w_op2_src    = load_i ? op2_i        : r_op2;
      w_op1_d      = w_op1_src;
      w_op2_d      = w_op2_src;
      // x0 is never written back, so a zero address never patches
      if (wb_we_i && (wb_waddr_i != '0) && (wb_waddr_i == w_rs1_src)) begin
         w_op1_d = wb_wdata_i;
      end
      if (wb_we_i && (wb_waddr_i != '0) && (wb_waddr_i == w_rs2_src) && w_is_reg_src) begin
         w_op2_d = wb_wdata_i;
      end
   end

   // Operands update every cycle (patching); the rest only on load
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_pc         <= '0;
         r_inst       <= INST_W'(INST_NOP);
         r_op1        <= '0;
         r_op2        <= '0;
         r_rs1        <= '0;
         r_rs2        <= '0;
         r_op2_is_reg <= 1'b0;
      end else begin
         r_op1 <= w_op1_d;
         r_op2 <= w_op2_d;
         if (load_i) begin
            r_pc         <= pc_i;
            r_inst       <= inst_i;
            r_rs1        <= rs1_i;
            r_rs2        <= rs2_i;
            r_op2_is_reg <= op2_is_reg_i;
         end
      end
   end

   assign rs1_o        = r_rs1;
   assign rs2_o        = r_rs2;
   assign op2_is_reg_o = r_op2_is_reg;
`else
   // Plain payload register, held verbatim until the next load
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_pc   <= '0;
         r_inst <= INST_W'(INST_NOP);
         r_op1  <= '0;
         r_op2  <= '0;
      end else if (load_i) begin
         r_pc   <= pc_i;
         r_inst <= inst_i;
         r_op1  <= op1_i;
         r_op2  <= op2_i;
      end
   end
`endif

   assign pc_o   = r_pc;
   assign inst_o = r_inst;
   assign op1_o  = r_op1;
   assign op2_o  = r_op2;

endmodule

// File: rtl/id_ex_stage.sv
// Decode->execute pipeline register with a 2-entry skid buffer (main entry M, skid entry S)
// and a registered in_ready_o. Optional write-back operand patching: define ID_EX_BYPASS_EN.
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter int unsigned DATA_W  = DATA_WIDTH,
   parameter int unsigned INST_W  = RDATA_WIDTH,
   parameter int unsigned RADDR_W = RADDR_WIDTH
) (
   input logic          clk_i,
   input logic          rst_n_i,
   id_ex_stage_if.slave bus
);

   state_t r_state;
   state_t w_state_d;
   logic   r_in_ready;
   logic   w_out_valid;
   logic   w_acc;
   logic   w_pop;
   logic   w_m_load;
   logic   w_s_load;
   logic   w_m_from_s;

   logic [DATA_W-1:0] w_m_pc_in, w_m_op1_in, w_m_op2_in;
   logic [INST_W-1:0] w_m_inst_in;
   logic [DATA_W-1:0] w_m_pc, w_m_op1, w_m_op2, w_s_pc, w_s_op1, w_s_op2;
   logic [INST_W-1:0] w_m_inst, w_s_inst;

   assign w_out_valid = (r_state != ST_EMPTY);
   assign w_acc       = bus.in_valid_i & r_in_ready;
   assign w_pop       = w_out_valid & bus.out_ready_i;
   // Only in TWO does M refill from S; elsewhere it captures decode directly
   assign w_m_from_s  = (r_state == ST_TWO);

   // Occupancy next state and entry load enables; flush overrides everything
   always_comb begin
      w_state_d = r_state;
      w_m_load  = 1'b0;
      w_s_load  = 1'b0;
      if (bus.flush_i) begin
         w_state_d = ST_EMPTY;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_acc) begin
                  w_m_load  = 1'b1;
                  w_state_d = ST_ONE;
               end
            end
            ST_ONE: begin
               if (w_acc && w_pop) begin
                  w_m_load = 1'b1;
               end else if (w_acc) begin
                  w_s_load  = 1'b1;
                  w_state_d = ST_TWO;
               end else if (w_pop) begin
                  w_state_d = ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (w_pop) begin
                  w_m_load  = 1'b1;
                  w_state_d = ST_ONE;
               end
            end
            default: w_state_d = ST_EMPTY;
         endcase
      end
   end

   // State and registered ready: ready drops only while both entries are occupied
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state    <= ST_EMPTY;
         r_in_ready <= 1'b1;
      end else begin
         r_state    <= w_state_d;
         r_in_ready <= (w_state_d != ST_TWO);
      end
   end

   // Source mux for the main entry
   always_comb begin
      w_m_pc_in   = w_m_from_s ? w_s_pc   : bus.pc_i;
      w_m_inst_in = w_m_from_s ? w_s_inst : bus.inst_i;
      w_m_op1_in  = w_m_from_s ? w_s_op1  : bus.op1_i;
      w_m_op2_in  = w_m_from_s ? w_s_op2  : bus.op2_i;
   end

`ifdef ID_EX_BYPASS_EN
   logic [RADDR_W-1:0] w_s_rs1, w_s_rs2, w_m_rs1_in, w_m_rs2_in, w_m_rs1, w_m_rs2;
   logic               w_s_is_reg, w_m_is_reg_in, w_m_is_reg;

   // Register-address source mux for the main entry
   always_comb begin
      w_m_rs1_in    = w_m_from_s ? w_s_rs1    : bus.rs1_i;
      w_m_rs2_in    = w_m_from_s ? w_s_rs2    : bus.rs2_i;
      w_m_is_reg_in = w_m_from_s ? w_s_is_reg : bus.op2_is_reg_i;
   end

   // M's stored addresses are only needed when patching, never read out
   logic w_unused_m_addr;
   assign w_unused_m_addr = ^{w_m_rs1, w_m_rs2, w_m_is_reg};
`else
   // Bypass inputs have no function in this build
   logic w_unused_bypass;
   assign w_unused_bypass = ^{bus.rs1_i, bus.rs2_i, bus.op2_is_reg_i, bus.wb_we_i,
                              bus.wb_waddr_i, bus.wb_wdata_i};
`endif

   id_ex_entry #(
      .DATA_W (DATA_W),
      .INST_W (INST_W),
      .RADDR_W(RADDR_W)
   ) u_main (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .load_i      (w_m_load),
      .pc_i        (w_m_pc_in),
      .inst_i      (w_m_inst_in),
      .op1_i       (w_m_op1_in),
      .op2_i       (w_m_op2_in),
`ifdef ID_EX_BYPASS_EN
      .rs1_i       (w_m_rs1_in),
      .rs2_i       (w_m_rs2_in),
      .op2_is_reg_i(w_m_is_reg_in),
      .wb_we_i     (bus.wb_we_i),
      .wb_waddr_i  (bus.wb_waddr_i),
      .wb_wdata_i  (bus.wb_wdata_i),
      .rs1_o       (w_m_rs1),
      .rs2_o       (w_m_rs2),
      .op2_is_reg_o(w_m_is_reg),
`endif
      .pc_o        (w_m_pc),
      .inst_o      (w_m_inst),
      .op1_o       (w_m_op1),
      .op2_o       (w_m_op2)
   );

   id_ex_entry #(
      .DATA_W (DATA_W),
      .INST_W (INST_W),
      .RADDR_W(RADDR_W)
   ) u_skid (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .load_i      (w_s_load),
      .pc_i        (bus.pc_i),
      .inst_i      (bus.inst_i),
      .op1_i       (bus.op1_i),
      .op2_i       (bus.op2_i),
`ifdef ID_EX_BYPASS_EN
      .rs1_i       (bus.rs1_i),
      .rs2_i       (bus.rs2_i),
      .op2_is_reg_i(bus.op2_is_reg_i),
      .wb_we_i     (bus.wb_we_i),
      .wb_waddr_i  (bus.wb_waddr_i),
      .wb_wdata_i  (bus.wb_wdata_i),
      .rs1_o       (w_s_rs1),
      .rs2_o       (w_s_rs2),
      .op2_is_reg_o(w_s_is_reg),
`endif
      .pc_o        (w_s_pc),
      .inst_o      (w_s_inst),
      .op1_o       (w_s_op1),
      .op2_o       (w_s_op2)
   );

   // Head payload, forced to NOP/zero whenever nothing valid is presented
   always_comb begin
      bus.in_ready_o  = r_in_ready;
      bus.out_valid_o = w_out_valid;
      bus.pc_o        = w_out_valid ? w_m_pc   : DATA_W'(ZERO);
      bus.inst_o      = w_out_valid ? w_m_inst : INST_W'(INST_NOP);
      bus.op1_o       = w_out_valid ? w_m_op1  : DATA_W'(ZERO);
      bus.op2_o       = w_out_valid ? w_m_op2  : DATA_W'(ZERO);
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage. Bypass expectations follow ID_EX_BYPASS_EN.
module tb_id_ex_stage;

`ifdef ID_EX_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   id_ex_stage_if #(.DATA_W(32), .INST_W(32), .RADDR_W(5)) bus ();

   id_ex_stage dut (
      .clk_i  (clk),
      .rst_n_i(rst_n),
      .bus    (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                         input logic [31:0] op1, input logic [31:0] op2,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic is_reg);
      bus.in_valid_i   = v;
      bus.pc_i         = pc;
      bus.inst_i       = inst;
      bus.op1_i        = op1;
      bus.op2_i        = op2;
      bus.rs1_i        = rs1;
      bus.rs2_i        = rs2;
      bus.op2_is_reg_i = is_reg;
   endtask

   task automatic set_wb(input logic we, input logic [4:0] addr, input logic [31:0] data);
      bus.wb_we_i    = we;
      bus.wb_waddr_i = addr;
      bus.wb_wdata_i = data;
   endtask

   task automatic test_reset();
      bus.flush_i = 1'b0;
      bus.out_ready_i = 1'b0;
      set_in(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0);
      set_wb(1'b0, 5'd0, 32'h0);
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      checks++; if (bus.out_valid_o !== 1'b0) begin errors++;
         $display("FAIL reset_valid: got %b want 0", bus.out_valid_o); end
      checks++; if (bus.in_ready_o !== 1'b1) begin errors++;
         $display("FAIL reset_ready: got %b want 1", bus.in_ready_o); end
      checks++; if (bus.inst_o !== 32'h0000_0013) begin errors++;
         $display("FAIL reset_inst: got %h want 00000013", bus.inst_o); end
      checks++; if (bus.pc_o !== 32'h0) begin errors++;
         $display("FAIL reset_pc: got %h want 0", bus.pc_o); end
   endtask

   task automatic test_addi_stream();
      bus.out_ready_i = 1'b1;
      set_in(1'b1, 32'h100, 32'h0050_0093, 32'h0, 32'h5, 5'd0, 5'd0, 1'b0);
      tick();
      checks++; if (bus.out_valid_o !== 1'b1) begin errors++;
         $display("FAIL addi_valid: got %b want 1", bus.out_valid_o); end
      checks++; if (bus.op2_o !== 32'h5) begin errors++;
         $display("FAIL addi_op2: got %h want 5", bus.op2_o); end
      checks++; if (bus.pc_o !== 32'h100) begin errors++;
         $display("FAIL addi_pc: got %h want 100", bus.pc_o); end
      checks++; if (bus.inst_o !== 32'h0050_0093) begin errors++;
         $display("FAIL addi_inst: got %h want 00500093", bus.inst_o); end
      for (int i = 0; i < 4; i++) begin
         set_in(1'b1, 32'h200 + 32'(4 * i), 32'h0000_0033, 32'(i), 32'(10 + i), 5'd0, 5'd0,
                1'b0);
         tick();
         checks++;
         if (bus.out_valid_o !== 1'b1 || bus.in_ready_o !== 1'b1 ||
             bus.pc_o !== 32'h200 + 32'(4 * i) || bus.op1_o !== 32'(i)) begin
            errors++;
            $display("FAIL stream_%0d: got v=%b r=%b pc=%h op1=%h want v=1 r=1 pc=%h op1=%h",
                     i, bus.out_valid_o, bus.in_ready_o, bus.pc_o, bus.op1_o,
                     32'h200 + 32'(4 * i), 32'(i));
         end
      end
      set_in(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0);
      tick();
      checks++; if (bus.out_valid_o !== 1'b0 || bus.inst_o !== 32'h13 || bus.op1_o !== 0) begin
         errors++;
         $display("FAIL stream_drain: got v=%b inst=%h op1=%h want v=0 inst=13 op1=0",
                  bus.out_valid_o, bus.inst_o, bus.op1_o); end
   endtask

   task automatic test_skid();
      bus.out_ready_i = 1'b0;
      set_in(1'b1, 32'h300, 32'h0010_0113, 32'h1, 32'h2, 5'd0, 5'd0, 1'b0);
      tick();
      checks++; if (bus.pc_o !== 32'h300 || bus.in_ready_o !== 1'b1) begin errors++;
         $display("FAIL skid_a: got pc=%h r=%b want pc=300 r=1", bus.pc_o, bus.in_ready_o); end
      set_in(1'b1, 32'h304, 32'h0020_0113, 32'h3, 32'h4, 5'd0, 5'd0, 1'b0);
      tick();
      checks++; if (bus.in_ready_o !== 1'b0) begin errors++;
         $display("FAIL skid_two_ready: got %b want 0", bus.in_ready_o); end
      checks++; if (bus.pc_o !== 32'h300 || bus.op1_o !== 32'h1) begin errors++;
         $display("FAIL skid_hold_a: got pc=%h op1=%h want 300/1", bus.pc_o, bus.op1_o); end
      set_in(1'b1, 32'h308, 32'h0030_0113, 32'h5, 32'h6, 5'd0, 5'd0, 1'b0);
      tick();
      checks++; if (bus.pc_o !== 32'h300 || bus.in_ready_o !== 1'b0) begin errors++;
         $display("FAIL skid_stall: got pc=%h r=%b want 300/0", bus.pc_o, bus.in_ready_o); end
      bus.out_ready_i = 1'b1;
      tick();
      checks++; if (bus.pc_o !== 32'h304 || bus.op1_o !== 32'h3 || bus.in_ready_o !== 1'b1)
      begin errors++;
         $display("FAIL skid_pop_b: got pc=%h op1=%h r=%b want 304/3/1", bus.pc_o, bus.op1_o,
                  bus.in_ready_o); end
      tick();
      checks++; if (bus.pc_o !== 32'h308 || bus.op1_o !== 32'h5 || bus.out_valid_o !== 1'b1)
      begin errors++;
         $display("FAIL skid_c: got pc=%h op1=%h v=%b want 308/5/1", bus.pc_o, bus.op1_o,
                  bus.out_valid_o); end
      set_in(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0);
      tick();
      checks++; if (bus.out_valid_o !== 1'b0) begin errors++;
         $display("FAIL skid_drain: got %b want 0", bus.out_valid_o); end
   endtask

   task automatic test_flush();
      bus.out_ready_i = 1'b0;
      set_in(1'b1, 32'h400, 32'h13, 32'h1, 32'h1, 5'd0, 5'd0, 1'b0);
      tick();
      set_in(1'b1, 32'h404, 32'h13, 32'h2, 32'h2, 5'd0, 5'd0, 1'b0);
      tick();
      set_in(1'b1, 32'h408, 32'h13, 32'h3, 32'h3, 5'd0, 5'd0, 1'b0);
      bus.flush_i = 1'b1;
      tick();
      checks++; if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1 || bus.pc_o !== 0)
      begin errors++;
         $display("FAIL flush_two: got v=%b r=%b pc=%h want 0/1/0", bus.out_valid_o,
                  bus.in_ready_o, bus.pc_o); end
      bus.flush_i = 1'b0;
      set_in(1'b1, 32'h40c, 32'h13, 32'h4, 32'h4, 5'd0, 5'd0, 1'b0);
      tick();
      checks++; if (bus.pc_o !== 32'h40c) begin errors++;
         $display("FAIL flush_refill: got %h want 40c", bus.pc_o); end
      // In ONE the stage is ready, so this accept would happen without the flush
      set_in(1'b1, 32'h410, 32'h13, 32'h5, 32'h5, 5'd0, 5'd0, 1'b0);
      bus.flush_i = 1'b1;
      tick();
      checks++; if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1) begin errors++;
         $display("FAIL flush_one: got v=%b r=%b want 0/1", bus.out_valid_o, bus.in_ready_o); end
      bus.flush_i = 1'b0;
      set_in(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0);
      bus.out_ready_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (bus.out_valid_o !== 1'b0) begin errors++;
            $display("FAIL flush_ghost_%0d: got v=%b pc=%h want v=0", i, bus.out_valid_o,
                     bus.pc_o); end
      end
   endtask

   task automatic test_bypass();
      logic [31:0] exp;
      bus.out_ready_i = 1'b0;
      set_in(1'b1, 32'h500, 32'h13, 32'h0, 32'h7, 5'd3, 5'd4, 1'b0);
      tick();
      set_in(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0);
      set_wb(1'b1, 5'd3, 32'hDEAD);
      tick();
      exp = BYP ? 32'hDEAD : 32'h0;
      checks++; if (bus.op1_o !== exp) begin errors++;
         $display("FAIL byp_rs1: got %h want %h", bus.op1_o, exp); end
      set_wb(1'b1, 5'd4, 32'hBEEF);
      tick();
      checks++; if (bus.op2_o !== 32'h7 || bus.op1_o !== exp) begin errors++;
         $display("FAIL byp_imm: got op2=%h op1=%h want 7/%h", bus.op2_o, bus.op1_o, exp); end
      set_wb(1'b1, 5'd0, 32'h1234);
      bus.flush_i = 1'b1;
      tick();
      bus.flush_i = 1'b0;
      set_in(1'b1, 32'h504, 32'h13, 32'h11, 32'h7, 5'd0, 5'd4, 1'b1);
      tick();
      checks++; if (bus.op1_o !== 32'h11) begin errors++;
         $display("FAIL byp_x0: got %h want 11", bus.op1_o); end
      set_in(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0);
      set_wb(1'b1, 5'd4, 32'hBEEF);
      tick();
      exp = BYP ? 32'hBEEF : 32'h7;
      checks++; if (bus.op2_o !== exp) begin errors++;
         $display("FAIL byp_rs2: got %h want %h", bus.op2_o, exp); end
      set_wb(1'b0, 5'd0, 32'h0);
      bus.flush_i = 1'b1;
      tick();
      bus.flush_i = 1'b0;
      // Write-back lands on the same cycle the entry is captured
      set_in(1'b1, 32'h508, 32'h13, 32'h22, 32'h0, 5'd5, 5'd0, 1'b0);
      set_wb(1'b1, 5'd5, 32'h55);
      tick();
      exp = BYP ? 32'h55 : 32'h22;
      checks++; if (bus.op1_o !== exp) begin errors++;
         $display("FAIL byp_capture: got %h want %h", bus.op1_o, exp); end
      set_wb(1'b0, 5'd0, 32'h0);
      set_in(1'b1, 32'h50c, 32'h13, 32'h66, 32'h0, 5'd6, 5'd0, 1'b0);
      tick();
      set_in(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0);
      set_wb(1'b1, 5'd6, 32'h77);
      tick();
      set_wb(1'b0, 5'd0, 32'h0);
      bus.out_ready_i = 1'b1;
      tick();
      exp = BYP ? 32'h77 : 32'h66;
      checks++; if (bus.pc_o !== 32'h50c || bus.op1_o !== exp) begin errors++;
         $display("FAIL byp_skid: got pc=%h op1=%h want 50c/%h", bus.pc_o, bus.op1_o, exp); end
      tick();
   endtask

   task automatic test_async_reset();
      bus.out_ready_i = 1'b0;
      set_in(1'b1, 32'h600, 32'h0000_0033, 32'h9, 32'h9, 5'd0, 5'd0, 1'b0);
      tick();
      set_in(1'b1, 32'h604, 32'h0000_0033, 32'hA, 32'hA, 5'd0, 5'd0, 1'b0);
      tick();
      checks++; if (bus.in_ready_o !== 1'b0 || bus.pc_o !== 32'h600) begin errors++;
         $display("FAIL arst_setup: got r=%b pc=%h want 0/600", bus.in_ready_o, bus.pc_o); end
      #3;
      rst_n = 1'b0;
      #1;
      checks++; if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1) begin errors++;
         $display("FAIL arst_ctrl: got v=%b r=%b want 0/1", bus.out_valid_o, bus.in_ready_o); end
      checks++; if (bus.inst_o !== 32'h13 || bus.pc_o !== 0 || bus.op1_o !== 0) begin errors++;
         $display("FAIL arst_data: got inst=%h pc=%h op1=%h want 13/0/0", bus.inst_o, bus.pc_o,
                  bus.op1_o); end
      set_in(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0);
      tick();
      rst_n = 1'b1;
      bus.out_ready_i = 1'b1;
      tick();
      checks++; if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1) begin errors++;
         $display("FAIL arst_after: got v=%b r=%b want 0/1", bus.out_valid_o, bus.in_ready_o); end
   endtask

   initial begin
      test_reset();
      test_addi_stream();
      test_skid();
      test_flush();
      test_bypass();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
